// File: rtl/rgb_to_ycbcr_stage.sv
// rgb_to_ycbcr_stage: full-range BT.601 RGB to serialized Y/Cb/Cr stream.
// Input capture, Q8 product stage, sum/clamp stage, 3-state serializer.
module rgb_to_ycbcr_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       valid_o,
    output logic [1:0] state_o,
    output logic [7:0] data_o
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT_Y,
        EMIT_CB,
        EMIT_CR
    } state_t;

    logic [1:0] issue_cnt;
    logic       accept;

    assign ready_o = (issue_cnt == 2'd0) && rst_n;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n)
            issue_cnt <= 2'd0;
        else if (accept)
            issue_cnt <= 2'd2;
        else if (issue_cnt != 2'd0)
            issue_cnt <= issue_cnt - 2'd1;
    end

    logic       in_valid;
    logic [7:0] r, g, b;

    always_ff @(posedge clk) begin
        if (!rst_n)
            in_valid <= 1'b0;
        else
            in_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r <= r_i;
            g <= g_i;
            b <= b_i;
        end
    end

    logic signed [19:0] rs, gs, bs;
    logic signed [19:0] yr, yg, yb;
    logic signed [19:0] cbr, cbg, cbb;
    logic signed [19:0] crr, crg, crb;
    logic               s1_valid;

    assign rs = {12'd0, r};
    assign gs = {12'd0, g};
    assign bs = {12'd0, b};

    always_ff @(posedge clk) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else
            s1_valid <= in_valid;
    end

    // Magnitudes only; signs are applied in the summing stage.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            yr  <= rs * 20'sd77;
            yg  <= gs * 20'sd150;
            yb  <= bs * 20'sd29;
            cbr <= rs * 20'sd43;
            cbg <= gs * 20'sd85;
            cbb <= bs * 20'sd128;
            crr <= rs * 20'sd128;
            crg <= gs * 20'sd107;
            crb <= bs * 20'sd21;
        end
    end

    function automatic logic [7:0] clamp(input logic signed [19:0] v);
        if (v < 20'sd0)
            return 8'd0;
        if (v > 20'sd255)
            return 8'hff;
        return v[7:0];
    endfunction

    logic signed [19:0] y_sum, cb_sum, cr_sum;
    logic [7:0]         y_n, cb_n, cr_n;

    assign y_sum  = yr + yg + yb + 20'sd128;
    assign cb_sum = cbb - cbr - cbg + 20'sd128;
    assign cr_sum = crr - crg - crb + 20'sd128;

    assign y_n  = clamp(y_sum >>> 8);
    assign cb_n = clamp((cb_sum >>> 8) + 20'sd128);
    assign cr_n = clamp((cr_sum >>> 8) + 20'sd128);

    logic [7:0] cb_h, cr_h;

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            cb_h <= cb_n;
            cr_h <= cr_n;
        end
    end

    state_t     state, state_n;
    logic       valid_n;
    logic [1:0] index_n;
    logic [7:0] data_n;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = IDLE;
        valid_n = 1'b0;
        index_n = 2'd0;
        data_n  = 8'd0;
        if (s1_valid) begin
            state_n = EMIT_Y;
        end else begin
            unique case (state)
                IDLE:    state_n = IDLE;
                EMIT_Y:  state_n = EMIT_CB;
                EMIT_CB: state_n = EMIT_CR;
                EMIT_CR: state_n = IDLE;
            endcase
        end
        unique case (1'b1)
            state_n == EMIT_Y: begin
                valid_n = 1'b1;
                index_n = 2'd0;
                data_n  = y_n;
            end
            state_n == EMIT_CB: begin
                valid_n = 1'b1;
                index_n = 2'd1;
                data_n  = cb_h;
            end
            state_n == EMIT_CR: begin
                valid_n = 1'b1;
                index_n = 2'd2;
                data_n  = cr_h;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            state_o <= 2'd0;
            data_o  <= 8'd0;
        end else begin
            valid_o <= valid_n;
            state_o <= index_n;
            data_o  <= data_n;
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr_stage.sv
// tb_rgb_to_ycbcr_stage: table vectors, reset corners and random pixels
// checked cycle by cycle against an arithmetic stream model.
module tb_rgb_to_ycbcr_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] r_i = 8'd0;
    logic [7:0] g_i = 8'd0;
    logic [7:0] b_i = 8'd0;
    logic       ready_o;
    logic       valid_o;
    logic [1:0] state_o;
    logic [7:0] data_o;

    always #5 clk = ~clk;

    rgb_to_ycbcr_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .r_i     (r_i),
        .g_i     (g_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .state_o (state_o),
        .data_o  (data_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int fdiv(input int n);
        if (n >= 0)
            return n / 256;
        return -((255 - n) / 256);
    endfunction

    function automatic int sat(input int v);
        if (v < 0)
            return 0;
        if (v > 255)
            return 255;
        return v;
    endfunction

    function automatic logic [23:0] ref_px(input int r, input int g,
                                           input int b);
        int y, cb, cr;
        y  = sat(fdiv(77 * r + 150 * g + 29 * b + 128));
        cb = sat(fdiv(-43 * r - 85 * g + 128 * b + 128) + 128);
        cr = sat(fdiv(128 * r - 107 * g - 21 * b + 128) + 128);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    typedef struct packed {
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
    } out_t;

    out_t sched [int];
    int   next_ok = 0;
    int   run = 0;
    int   last_run = 0;
    bit   mon = 1'b0;

    // Expected stream: an accept at cycle n shows Y/Cb/Cr at n+3..n+5.
    always @(negedge clk) begin
        out_t        e;
        logic        er;
        logic [23:0] p;
        cyc++;
        if (mon) begin
            e  = sched.exists(cyc) ? sched[cyc] : '0;
            er = rst_n && (cyc >= next_ok);
            chk("ready", int'(ready_o), int'(er));
            chk("valid", int'(valid_o), int'(e.v));
            chk("state", int'(state_o), int'(e.s));
            chk("data", int'(data_o), int'(e.d));
            if (!rst_n) begin
                sched.delete();
                next_ok = cyc + 1;
            end else if (valid_i && er) begin
                p = ref_px(int'(r_i), int'(g_i), int'(b_i));
                sched[cyc + 3] = {1'b1, 2'd0, p[23:16]};
                sched[cyc + 4] = {1'b1, 2'd1, p[15:8]};
                sched[cyc + 5] = {1'b1, 2'd2, p[7:0]};
                next_ok = cyc + 3;
            end
            if (valid_o) begin
                run++;
            end else begin
                if (run != 0)
                    last_run = run;
                run = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, output int at);
        valid_i = 1'b1;
        r_i = r;
        g_i = g;
        b_i = b;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ready_o) begin
                at = cyc;
                break;
            end
        end
        if (at < 0)
            chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic expect_px(input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!valid_o && n < 10);
        if (!valid_o) begin
            chk("output_timeout", 0, 1);
        end else begin
            chk("tbl_y_state", int'(state_o), 0);
            chk("tbl_y", int'(data_o), int'(y));
            @(negedge clk);
            #1;
            chk("tbl_cb_state", int'(state_o), 1);
            chk("tbl_cb", int'(data_o), int'(cb));
            @(negedge clk);
            #1;
            chk("tbl_cr_state", int'(state_o), 2);
            chk("tbl_cr", int'(data_o), int'(cr));
            @(negedge clk);
            #1;
            chk("tbl_tail_valid", int'(valid_o), 0);
        end
    endtask

    typedef struct packed {
        logic [7:0] r, g, b, y, cb, cr;
    } vec_t;

    vec_t tbl [4];
    int   at [4];
    int   dummy;
    int   n;

    initial begin
        tbl[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128};
        tbl[1] = '{8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255};
        tbl[2] = '{8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107};
        tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128};

        repeat (3) @(posedge clk);
        #1;
        mon = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].r, tbl[i].g, tbl[i].b, dummy);
            expect_px(tbl[i].y, tbl[i].cb, tbl[i].cr);
            idle(2);
        end

        for (int i = 0; i < 4; i++)
            send(tbl[i].r, tbl[i].g, tbl[i].b, at[i]);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", at[i] - at[i - 1], 3);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (valid_o && n < 20);
        chk("b2b_run_len", last_run, 12);
        idle(3);

        send(8'd255, 8'd255, 8'd255, dummy);
        send(8'd0, 8'd0, 8'd255, dummy);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_reset_state", int'(state_o), 1);
        @(negedge clk);
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_ready", int'(ready_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (valid_o)
                n++;
        end
        chk("no_stale", n, 0);
        idle(1);
        send(8'd0, 8'd0, 8'd255, dummy);
        expect_px(8'd29, 8'd255, 8'd107);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), dummy);
            idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 20; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), dummy);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
